// File: rtl/cd_pkg.sv
// Shared constants and types for the cdbus RX fetch engine: CSR map of the
// cdbus core, flag bit positions, control command values and the FSM states.
package cd_pkg;

  localparam logic [4:0] A_INT_FLAG = 5'h10;
  localparam logic [4:0] A_RX_CTRL  = 5'h14;
  localparam logic [4:0] A_RX_LEN   = 5'h15;
  localparam logic [4:0] A_RX_DATA  = 5'h16;

  localparam int B_RX_PEND = 1;
  localparam int B_RX_ERR  = 3;

  localparam logic [7:0] C_RX_DONE = 8'h01;
  localparam logic [7:0] C_RX_CLR  = 8'h10;

  typedef enum logic [3:0] {
    IDLE,
    STAT,
    STAT_W,
    CLR_E,
    LEN,
    LEN_W,
    DATA,
    DATA_W,
    DONE
  } state_t;

  // Increment that sticks at 255 so a long error storm never wraps the count.
  function automatic logic [7:0] satInc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/cd_fifo2.sv
// Two-entry register FIFO holding {data, last} for the outgoing byte stream.
// Head entry drives the stream outputs directly, so data/last are stable
// while a byte waits for the consumer.
module cd_fifo2 (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_push,
  input  logic [8:0] i_din,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [8:0] o_dout,
  output logic [1:0] o_count
);

  logic [8:0] r_head;
  logic [8:0] r_tail;
  logic [1:0] r_count;
  logic       w_pop;

  assign w_pop   = (r_count != 2'd0) && i_ready;
  assign o_valid = (r_count != 2'd0);
  assign o_dout  = r_head;
  assign o_count = r_count;

  // Storage and occupancy; a simultaneous push and pop keeps the count unchanged.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_din;
          else                 r_tail <= i_din;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= i_din;
          end else begin
            r_head <= r_tail;
            r_tail <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  a_noPushWhenFull: assert property (@(posedge i_clk) disable iff (i_reset)
                                      !(i_push && (r_count == 2'd2)));

endmodule

// File: rtl/cd_rx_fetch.sv
// CSR master that drains received frames from the cdbus core RX page and
// replays them as a byte stream with a last-byte marker, then releases the
// page. Started by irq or by a periodic status poll while idle.
module cd_rx_fetch
  import cd_pkg::*;
#(
  parameter int unsigned POLL_DIV = 1024
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_irq,
  output logic [4:0] o_csr_address,
  output logic       o_csr_read,
  input  logic [7:0] i_csr_readdata,
  output logic       o_csr_write,
  output logic [7:0] o_csr_writedata,
  output logic [7:0] o_m_data,
  output logic       o_m_valid,
  output logic       o_m_last,
  input  logic       i_m_ready,
  output logic [7:0] o_err_cnt
);

  localparam int PW = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);

  state_t        r_state;
  logic [PW-1:0] r_pollCnt;
  logic [7:0]    r_remain;
  logic [7:0]    r_errCnt;

  logic          w_pollHit;
  logic          w_room;
  logic          w_fifoEmpty;
  logic          w_push;
  logic [8:0]    w_pushWord;
  logic [8:0]    w_headWord;
  logic [1:0]    w_fifoCount;

  assign w_pollHit   = (POLL_DIV != 0) && (r_pollCnt == POLL_LAST);
  assign w_fifoEmpty = (w_fifoCount == 2'd0);
  assign w_room      = w_fifoEmpty || ((w_fifoCount == 2'd1) && i_m_ready);
  assign w_push      = (r_state == DATA_W);
  assign w_pushWord  = {i_csr_readdata, (r_remain == 8'd1)};

  assign o_m_data  = w_headWord[8:1];
  assign o_m_last  = w_headWord[0];
  assign o_err_cnt = r_errCnt;

  cd_fifo2 u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_din   (w_pushWord),
    .i_ready (i_m_ready),
    .o_valid (o_m_valid),
    .o_dout  (w_headWord),
    .o_count (w_fifoCount)
  );

  // CSR strobes decoded from the state so the DATA read can react to this cycle's m_ready.
  always_comb begin
    o_csr_address   = '0;
    o_csr_read      = 1'b0;
    o_csr_write     = 1'b0;
    o_csr_writedata = '0;
    case (r_state)
      STAT: begin
        o_csr_address = A_INT_FLAG;
        o_csr_read    = 1'b1;
      end
      LEN: begin
        o_csr_address = A_RX_LEN;
        o_csr_read    = 1'b1;
      end
      DATA: begin
        o_csr_address = A_RX_DATA;
        o_csr_read    = w_room;
      end
      CLR_E: begin
        o_csr_address   = A_RX_CTRL;
        o_csr_write     = 1'b1;
        o_csr_writedata = C_RX_CLR;
      end
      DONE: begin
        o_csr_address   = A_RX_CTRL;
        o_csr_write     = w_fifoEmpty;
        o_csr_writedata = C_RX_DONE;
      end
      default: ;
    endcase
  end

  // Fetch sequencer: status check, error clear, length read, byte reads, page release.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_pollCnt <= '0;
      r_remain  <= 8'd0;
      r_errCnt  <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_pollCnt <= w_pollHit ? '0 : r_pollCnt + 1'b1;
          if (i_irq || w_pollHit) r_state <= STAT;
        end
        STAT:   r_state <= STAT_W;
        STAT_W: begin
          if (i_csr_readdata[B_RX_ERR])       r_state <= CLR_E;
          else if (i_csr_readdata[B_RX_PEND]) r_state <= LEN;
          else                                r_state <= IDLE;
        end
        CLR_E: begin
          r_errCnt <= satInc(r_errCnt);
          r_state  <= IDLE;
        end
        LEN:    r_state <= LEN_W;
        LEN_W: begin
          if (i_csr_readdata == 8'd0) begin
            r_state <= DONE;
          end else begin
            r_remain <= i_csr_readdata;
            r_state  <= DATA;
          end
        end
        DATA: begin
          if (w_room) r_state <= DATA_W;
        end
        DATA_W: begin
          r_remain <= r_remain - 8'd1;
          r_state  <= (r_remain == 8'd1) ? DONE : DATA;
        end
        DONE: begin
          if (w_fifoEmpty) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cd_rx_fetch.sv
// Directed bench for cd_rx_fetch: a behavioural cdbus core model answers the
// CSR port, a monitor logs reads, writes and stream transfers, and the main
// sequence compares the logs against hand-computed expectations.
module tb_cd_rx_fetch;

  localparam logic [4:0] ADDR_INT_FLAG = 5'h10;
  localparam logic [4:0] ADDR_RX_CTRL  = 5'h14;
  localparam logic [4:0] ADDR_RX_LEN   = 5'h15;
  localparam logic [4:0] ADDR_RX_DATA  = 5'h16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       irq;
  logic       m_ready = 1'b1;
  logic [7:0] csr_readdata = 8'h00;
  logic [4:0] csr_address;
  logic       csr_read, csr_write;
  logic [7:0] csr_writedata, m_data, err_cnt;
  logic       m_valid, m_last;

  // core model state
  bit         irqEn = 1'b0, pend = 1'b0, errFlag = 1'b0;
  int         errLeft = 0, frameLen = 0, rdPtr = 0;
  logic [7:0] frameMem [8];

  // logs
  int         cyc = -1, firstStatCyc = -1;
  logic [4:0] rdAddrQ[$];
  logic [12:0] wrQ[$];
  logic [8:0] streamQ[$];
  int         xferCycQ[$];
  int         nDataRd = 0, nLenRd = 0, nDoneWr = 0, nClrWr = 0;
  int         validCnt = 0, stallViol = 0, bufViol = 0;
  logic       prevValid = 1'b0, prevReady = 1'b0, prevLast = 1'b0;
  logic [7:0] prevData = 8'h00;

  int         nChecks = 0, nFails = 0;
  bit         hit;

  assign irq = irqEn & (pend | errFlag);

  cd_rx_fetch #(.POLL_DIV(16)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_irq           (irq),
    .o_csr_address   (csr_address),
    .o_csr_read      (csr_read),
    .i_csr_readdata  (csr_readdata),
    .o_csr_write     (csr_write),
    .o_csr_writedata (csr_writedata),
    .o_m_data        (m_data),
    .o_m_valid       (m_valid),
    .o_m_last        (m_last),
    .i_m_ready       (m_ready),
    .o_err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  // Core model plus monitor: answers reads one cycle later and logs all bus activity.
  always @(posedge clk) begin
    if (reset) begin
      cyc <= -1;
      firstStatCyc = -1;
      prevValid = 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (csr_read) begin
        rdAddrQ.push_back(csr_address);
        case (csr_address)
          ADDR_INT_FLAG: begin
            if (firstStatCyc < 0) firstStatCyc = cyc;
            csr_readdata <= {4'b0000, errFlag, 1'b0, pend, 1'b0};
          end
          ADDR_RX_LEN: begin
            nLenRd++;
            rdPtr = 0;
            csr_readdata <= frameLen[7:0];
          end
          ADDR_RX_DATA: begin
            nDataRd++;
            csr_readdata <= (rdPtr < 8) ? frameMem[rdPtr] : 8'hEE;
            rdPtr++;
          end
          default: csr_readdata <= 8'hEE;
        endcase
      end
      if (csr_write) begin
        wrQ.push_back({csr_address, csr_writedata});
        if (csr_address == ADDR_RX_CTRL && csr_writedata == 8'h01) begin
          nDoneWr++;
          pend = 1'b0;
        end
        if (csr_address == ADDR_RX_CTRL && csr_writedata == 8'h10) begin
          nClrWr++;
          if (errLeft > 0) errLeft--;
          errFlag = (errLeft > 0);
        end
      end
      if (m_valid) validCnt++;
      if (m_valid && m_ready) begin
        streamQ.push_back({m_data, m_last});
        xferCycQ.push_back(cyc);
      end
      if (prevValid && !prevReady &&
          (!m_valid || m_data != prevData || m_last != prevLast)) stallViol++;
      if (nDataRd - streamQ.size() > 2) bufViol++;
      prevValid = m_valid;
      prevReady = m_ready;
      prevData  = m_data;
      prevLast  = m_last;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearLogs();
    rdAddrQ.delete();
    wrQ.delete();
    streamQ.delete();
    xferCycQ.delete();
    nDataRd = 0; nLenRd = 0; nDoneWr = 0; nClrWr = 0;
    validCnt = 0; stallViol = 0; bufViol = 0;
  endtask

  task automatic applyStimulus(input bit irqOn, input bit pendOn, input int len,
                               input int errs, input logic [39:0] bytes);
    clearLogs();
    for (int i = 0; i < 5; i++) frameMem[i] = bytes[39-8*i -: 8];
    for (int i = 5; i < 8; i++) frameMem[i] = 8'hEE;
    frameLen = len;
    errLeft  = errs;
    errFlag  = (errs > 0);
    pend     = pendOn;
    irqEn    = irqOn;
  endtask

  task automatic checkFrame(input string tag, input int len, input logic [39:0] bytes);
    checkOutput({tag, "_count"}, streamQ.size(), len);
    for (int i = 0; i < len; i++)
      checkOutput($sformatf("%s_b%0d", tag, i),
                  (i < streamQ.size()) ? streamQ[i] : 9'h1FF,
                  {bytes[39-8*i -: 8], (i == len - 1)});
  endtask

  task automatic waitDone(input string tag, input int budget);
    for (int i = 0; i < budget && nDoneWr < 1; i++) @(negedge clk);
    checkOutput({tag, "_done"}, nDoneWr, 1);
  endtask

  initial begin
    // reset state
    applyStimulus(1'b0, 1'b0, 3, 0, 40'h01_02_05_00_00);
    repeat (3) @(negedge clk);
    checkOutput("rst_csr_read", csr_read, 0);
    checkOutput("rst_csr_write", csr_write, 0);
    checkOutput("rst_csr_address", csr_address, 0);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_last", m_last, 0);
    checkOutput("rst_m_data", m_data, 0);
    checkOutput("rst_err_cnt", err_cnt, 0);

    // polled fetch: no irq, pending appears at cycle 5, first status read at cycle 15
    $display("[TB] polled fetch");
    reset = 1'b0;
    while (cyc < 5) @(negedge clk);
    pend = 1'b1;
    waitDone("poll", 200);
    checkOutput("poll_first_stat_cycle", firstStatCyc, 15);
    checkFrame("poll", 3, 40'h01_02_05_00_00);

    // irq-driven fetch with m_ready high
    $display("[TB] irq fetch");
    applyStimulus(1'b1, 1'b1, 3, 0, 40'h01_02_05_00_00);
    waitDone("t1", 200);
    checkOutput("t1_rd0", rdAddrQ[0], ADDR_INT_FLAG);
    checkOutput("t1_rd1", rdAddrQ[1], ADDR_RX_LEN);
    checkOutput("t1_rd2", rdAddrQ[2], ADDR_RX_DATA);
    checkOutput("t1_rd3", rdAddrQ[3], ADDR_RX_DATA);
    checkOutput("t1_rd4", rdAddrQ[4], ADDR_RX_DATA);
    checkOutput("t1_data_reads", nDataRd, 3);
    checkFrame("t1", 3, 40'h01_02_05_00_00);
    checkOutput("t1_wr_count", wrQ.size(), 1);
    checkOutput("t1_wr0", wrQ[0], 13'h1401);
    checkOutput("t1_gap01", xferCycQ[1] - xferCycQ[0], 2);
    checkOutput("t1_gap12", xferCycQ[2] - xferCycQ[1], 2);

    // back-pressure: m_ready low for 10 cycles after the first byte
    $display("[TB] stalled fetch");
    applyStimulus(1'b1, 1'b1, 3, 0, 40'h01_02_05_00_00);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (streamQ.size() >= 1) hit = 1'b1;
    end
    checkOutput("stall_first_byte", hit, 1);
    m_ready = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("stall_reads_held", nDataRd, 2);
    checkOutput("stall_valid_held", m_valid, 1);
    checkOutput("stall_data_held", m_data, 8'h02);
    m_ready = 1'b1;
    waitDone("stall", 200);
    checkFrame("stall", 3, 40'h01_02_05_00_00);
    checkOutput("stall_stable", stallViol, 0);
    checkOutput("stall_buffered", bufViol, 0);

    // single RX error
    $display("[TB] rx error");
    checkOutput("err_cnt_before", err_cnt, 0);
    applyStimulus(1'b1, 1'b0, 0, 1, 40'h0);
    for (int i = 0; i < 200 && nClrWr < 1; i++) @(negedge clk);
    @(negedge clk);
    checkOutput("err_clr_writes", nClrWr, 1);
    checkOutput("err_wr0", wrQ[0], 13'h1410);
    checkOutput("err_cnt_one", err_cnt, 1);
    checkOutput("err_no_stream", validCnt, 0);
    checkOutput("err_no_len_read", nLenRd, 0);

    // error storm saturates the counter
    $display("[TB] error storm");
    applyStimulus(1'b1, 1'b0, 0, 300, 40'h0);
    for (int i = 0; i < 5000 && nClrWr < 300; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    checkOutput("storm_clr_writes", nClrWr, 300);
    checkOutput("storm_err_cnt", err_cnt, 255);

    // zero-length page is released without streaming
    $display("[TB] zero length");
    applyStimulus(1'b1, 1'b1, 0, 0, 40'h0);
    waitDone("len0", 200);
    checkOutput("len0_rd0", rdAddrQ[0], ADDR_INT_FLAG);
    checkOutput("len0_rd1", rdAddrQ[1], ADDR_RX_LEN);
    checkOutput("len0_data_reads", nDataRd, 0);
    checkOutput("len0_valid", validCnt, 0);
    checkOutput("len0_wr0", wrQ[0], 13'h1401);

    // reset in the middle of a 5-byte frame, during DATA_W of byte 2
    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 1'b1, 5, 0, 40'hA1_A2_A3_A4_A5);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (csr_read && csr_address == ADDR_RX_DATA && nDataRd == 1) hit = 1'b1;
    end
    checkOutput("mid_found_byte2", hit, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_csr_read", csr_read, 0);
    checkOutput("mid_csr_write", csr_write, 0);
    checkOutput("mid_csr_address", csr_address, 0);
    checkOutput("mid_m_valid", m_valid, 0);
    checkOutput("mid_m_last", m_last, 0);
    checkOutput("mid_m_data", m_data, 0);
    checkOutput("mid_err_cnt", err_cnt, 0);
    checkOutput("mid_not_released", nDoneWr, 0);
    @(negedge clk);
    clearLogs();
    reset = 1'b0;
    waitDone("refetch", 300);
    checkOutput("refetch_rd0", rdAddrQ[0], ADDR_INT_FLAG);
    checkOutput("refetch_rd1", rdAddrQ[1], ADDR_RX_LEN);
    checkOutput("refetch_data_reads", nDataRd, 5);
    checkFrame("refetch", 5, 40'hA1_A2_A3_A4_A5);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
